// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, combinational-read imem address, registered valid/ready output to decode.
// Optional `FETCH_COUNTERS_EN adds fetch_count / stall_count performance outputs.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WORDS    = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] read_address,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
`ifdef FETCH_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic {FETCH, FAULT} state_t;

  localparam logic [31:0] LIMIT = 32'(WORDS * 4);

  state_t      state_q, state_d;
  logic [31:0] pc;
  logic        addr_bad;
  logic        do_redirect;
  logic        do_fault;
  logic        do_capture;

  assign read_address = pc;
  assign fault        = (state_q == FAULT);
  assign addr_bad     = (pc[1:0] != 2'b00) || (pc >= LIMIT);

  // Redirect outranks the address check so a bad PC can still be steered away.
  always_comb begin
    state_d     = state_q;
    do_redirect = 1'b0;
    do_fault    = 1'b0;
    do_capture  = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          do_redirect = 1'b1;
        end else if (addr_bad) begin
          do_fault = 1'b1;
          state_d  = FAULT;
        end else if (!out_valid || out_ready) begin
          do_capture = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stage boundary: fetch -> decode output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FETCH;
      pc              <= RESET_PC;
      out_valid       <= 1'b0;
      out_instruction <= 32'h0;
      out_pc          <= 32'h0;
      fault_pc        <= 32'h0;
    end else begin
      state_q <= state_d;
      if (do_redirect) begin
        pc        <= redirect_target;
        out_valid <= 1'b0;
      end
      if (do_fault) begin
        fault_pc  <= pc;
        out_valid <= 1'b0;
      end
      if (do_capture) begin
        out_instruction <= instruction;
        out_pc          <= pc;
        out_valid       <= 1'b1;
        pc              <= pc + 32'd4;
      end else if (!do_redirect && !do_fault && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (out_valid && out_ready)  fetch_count <= fetch_count + 32'd1;
      if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch stage for the RV32I core: owns the program counter, drives the word-aligned address into the combinational-read instruction memory, and registers the returned word with its PC into a valid/ready output stage for decode. Handles branch/jump redirects from execute, back-pressure from decode, and halts with a sticky fault on misaligned or out-of-range fetch addresses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `WORDS`, default 64: instruction memory depth in 32-bit words. The legal byte range is 0 .. WORDS*4-1.
- `clk` in 1: single clock. All state updates on posedge.
- `reset` in 1: synchronous, active-high reset.
- `read_address` out 32: byte address to instruction memory. Combinationally equal to `pc`.
- `instruction` in 32: word returned combinationally by memory for `read_address` in the same cycle.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_target` in 32: new PC, byte address.
- `out_valid` out 1: `out_instruction`/`out_pc` hold a fetched instruction.
- `out_ready` in 1: decode accepts this cycle.
- `out_instruction` out 32: registered instruction word.
- `out_pc` out 32: byte address of `out_instruction`.
- `fault` out 1: sticky; fetch stopped on a bad address.
- `fault_pc` out 32: offending address.

## Operation
- States: FETCH and FAULT. Reset enters FETCH.
- Address check (in FETCH, every cycle on the candidate `pc`): bad if `pc[1:0] != 2'b00` or `pc >= WORDS*4`. A bad `pc` causes the following at the next edge: state <= FAULT, `fault` <= 1, `fault_pc` <= `pc`, `out_valid` <= 0. No capture occurs.
- Capture (FETCH, `pc` good, no redirect, and `!out_valid || out_ready`):
  - `out_instruction` <= `instruction`, `out_pc` <= `pc`, `out_valid` <= 1.
  - `pc` <= `pc` + 4, computed modulo 2^32. Wrap-around is caught by the range check before it matters.
- Hold (`out_valid && !out_ready`, no redirect): all registers keep their values. `pc` does not advance.
- Drain (`out_valid && out_ready`, no capture possible): `out_valid` <= 0.
- Redirect (`redirect_valid`, any FETCH cycle): highest priority.
  - `pc` <= `redirect_target`, `out_valid` <= 0, no capture this cycle.
  - The target is checked on the following cycle as the new `pc`.
  - If `out_valid && out_ready` holds in the same cycle, the handshake still counts as a transfer. Decode is flushed by the same redirect.
- FAULT: absorbing state. `out_valid` = 0, `pc` is frozen, and `redirect_valid` and `out_ready` are ignored. Only `reset` leaves FAULT.
- `read_address` always equals `pc`, including in FAULT and during a hold.

## Timing
- Reset values: `pc`=RESET_PC, `out_valid`=0, `out_instruction`=0, `out_pc`=0, `fault`=0, `fault_pc`=0, state=FETCH.
- Reset asserted mid-operation overrides every other input at that edge.
- Latency: `read_address`=A in cycle n gives `out_valid`=1 with `out_pc`=A in cycle n+1.
- Throughput: one instruction per cycle while `out_ready` stays high.
- Redirect penalty: redirect asserted in cycle n gives `read_address`=target in n+1 and the first valid output in n+2.
- Fault detection: a bad `pc` in cycle n gives `fault`=1 in n+1.
- `out_instruction`/`out_pc` are stable while `out_valid && !out_ready`.

## Configuration
- `FETCH_COUNTERS_EN` defined adds two outputs, both reset to 0 and wrapping at 2^32:
  - `fetch_count` out 32: increments on each `out_valid && out_ready` transfer.
  - `stall_count` out 32: increments on each cycle with `out_valid && !out_ready`.
- Undefined: the ports and logic are absent. The remaining behaviour is identical.

## Test plan
- Reset with RESET_PC=0, memory words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193, `out_ready`=1 held -> `out_pc` 0,4,8,12 on consecutive cycles starting the cycle after reset drops, with matching instructions.
- Back-pressure: `out_ready`=0 for 3 cycles while `out_pc`=4 -> `out_pc`/`out_instruction` stable, `read_address` stays 8. `out_ready`=1 -> `out_pc`=8 next cycle.
- Redirect to 0x20 while `out_pc`=4 is presented -> `out_valid`=0 next cycle, `read_address`=0x20, then `out_pc`=0x20 one cycle later.
- Redirect to 0x22 (misaligned) -> `fault`=1 and `fault_pc`=0x22 two cycles later. `out_valid` stays 0 even with later redirect to 0x0. Reset clears `fault` and restarts at RESET_PC.
- With WORDS=4, sequential fetch past 0xC -> `fault`=1, `fault_pc`=0x10, exactly four instructions delivered.
- With `FETCH_COUNTERS_EN`: 4 transfers and 3 stall cycles -> `fetch_count`=4, `stall_count`=3. Both read 0 after reset.
